// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam int unsigned WAIT_CYCLES_MAX = 15;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
) ();

    logic              MemEn;
    logic              MemWen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;
    logic              overrun;

    modport master (
        output MemEn, MemWen, addr, wdata,
        input  rdata, ack, busy, err, overrun
    );

    modport slave (
        input  MemEn, MemWen, addr, wdata,
        output rdata, ack, busy, err, overrun
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous RAM with registered read; no reset so it maps onto block RAM.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one request, inserts wait states, accesses RAM, pulses ack.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_EFF);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic              overrun_q;
    logic              rd_valid;
    logic              in_range;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
    assign bus.err  = err_q;
`else
    logic unused_addr_q;
    assign unused_addr_q = ^addr_q;
    assign in_range      = 1'b1;
    assign bus.err       = 1'b0;
`endif

    assign arr_we = (state == ACCESS) && wen_q && in_range;
    assign arr_re = (state == ACCESS) && !wen_q && in_range;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            rd_valid  <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            if (bus.MemEn && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.MemEn) begin
                        wen_q   <= bus.MemWen;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt     <= WAIT_LD;
                        state   <= (WAIT_EFF > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    ack_q <= 1'b1;
                    state <= RESP;
                    // rdata is the RAM read register gated by rd_valid, so reset and faults show 0
                    if (!in_range) begin
                        rd_valid <= 1'b0;
                    end else if (!wen_q) begin
                        rd_valid <= 1'b1;
                    end
`ifdef DMEM_RANGE_CHECK_EN
                    err_q <= !in_range;
`endif
                end
                RESP: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
`ifdef DMEM_RANGE_CHECK_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata   = rd_valid ? arr_rdata : '0;
    assign bus.ack     = ack_q;
    assign bus.busy    = (state != IDLE);
    assign bus.overrun = overrun_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder: the target side of the control unit's `MemEn`/`MemWen` memory strobe. It captures a one-cycle access request from the control FSM's EXECUTE state, inserts a configurable number of wait states, performs a single-word read or write on an internal synchronous RAM, and returns a one-cycle `ack` with registered read data. It sits between the control unit/datapath and the data store, replacing a zero-latency combinational memory.

## Interface
Parameters:
- `DATA_W`, 32: word width.
- `ADDR_W`, 16: request address width (ALU result bits used).
- `DEPTH`, 1024: words in the array; power of two, ≤ 2^ADDR_W.
- `WAIT_CYCLES`, 1: wait states inserted before the access, range 0..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemEn`  in  1  access request strobe, one cycle wide.
- `MemWen`  in  1  1 = write, 0 = read; sampled with `MemEn`.
- `addr`  in  ADDR_W  word address; sampled with `MemEn`.
- `wdata`  in  DATA_W  write data; sampled with `MemEn`.
- `rdata`  out  DATA_W  registered read data.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  request in flight.
- `err`  out  1  address fault, valid with `ack`.
- `overrun`  out  1  sticky: a request was dropped while busy.

## Operation
- Request capture:
  - In IDLE, `MemEn=1` latches `MemWen`, `addr` and `wdata` into request registers.
  - The wait counter loads `WAIT_CYCLES`.
  - State becomes WAIT if `WAIT_CYCLES>0`, otherwise ACCESS.
- WAIT: the counter decrements each cycle. At 1 it moves to ACCESS.
- ACCESS:
  - Write: `array[idx] <= wdata_q`.
  - Read: `rdata <= array[idx]`.
  - `ack` is registered high and state becomes RESP.
- RESP: `ack=1` for exactly this cycle, then the block returns to IDLE.
- `busy` = (state != IDLE), decoded from the state register.
- Request while busy:
  - Any `MemEn=1` seen in WAIT, ACCESS or RESP is dropped.
  - The drop sets `overrun`, which clears only on reset.
  - The in-flight access is unaffected.
- `rdata` holds its last read value through writes and idle time. A write never changes `rdata`.
- Index: `idx = addr_q[log2(DEPTH)-1:0]`.

## Timing
- Reset (`reset=0`, asynchronous):
  - State → IDLE, counter = 0.
  - `ack=0`, `busy=0`, `err=0`, `overrun=0`, `rdata=0`.
  - Array contents are not reset.
- Latency: with `MemEn` sampled at edge k, `ack` is high in the cycle after edge k+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: `ack` in the cycle after edge k+1.
  - WAIT_CYCLES=1: `ack` in the cycle after edge k+2.
- `rdata` and the array update change on the same edge that raises `ack`.
- `busy` is high from the cycle after edge k through the `ack` cycle inclusive.
- The earliest next accepted request is sampled at the edge that ends the `ack` cycle, with state already back in IDLE. `MemEn` during the `ack` cycle itself is dropped.
- Reset asserted mid-request (WAIT or ACCESS): the pending write is discarded, no `ack` is generated, and the array is untouched unless its write edge already occurred.
- `MemWen` without `MemEn` is ignored.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined:
  - The full `addr_q` is compared against `DEPTH`.
  - `addr_q >= DEPTH`: no array access, `rdata` is forced to 0, and `err=1` together with `ack`.
  - The normal latency is kept.
- Not defined:
  - No compare; the address wraps modulo `DEPTH` via the index truncation.
  - `err` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - the state typedef (IDLE, WAIT, ACCESS, RESP; 2 bits);
  - the `WAIT_CYCLES` maximum constant (15);
  - the counter width (4).
- Sub-module `dmem_array`: single-port synchronous RAM (`DEPTH`×`DATA_W`) with write enable and registered read. It carries no reset, so it infers block RAM.
- Top level holds: FSM, wait counter, request registers, flags.

## Test plan
- Reset, then WAIT_CYCLES=1: write 0xDEADBEEF to addr 5 (edge k), then read addr 5.
  - Each access: `ack` in the cycle after edge k+2.
  - The read returns `rdata=0xDEADBEEF`.
  - `busy` is high for 3 cycles per access.
- WAIT_CYCLES=0: back-to-back read of addr 0 with `MemEn` re-asserted the cycle after `ack`.
  - Both accesses are accepted.
  - Each `ack` follows its capture edge by 1 edge.
  - `overrun` stays 0.
- `MemEn` pulsed during WAIT, with a write of 0x1234 to addr 7:
  - `overrun=1` and remains set.
  - Only the first access completes.
  - Addr 7 keeps its prior value.
- Reset pulsed during WAIT of a write of 0xAAAA5555 to addr 3:
  - No `ack` occurs.
  - A later read of addr 3 returns the prior value.
  - Outputs read 0 immediately.
- `DMEM_RANGE_CHECK_EN`, DEPTH=1024: read of addr 0x0400 gives `ack=1`, `err=1`, `rdata=0`. Without the macro, the same read returns the contents of addr 0 with `err=0`.
